// File: rtl/tick_sched_ctrl.sv
// tick_sched_ctrl: single-clock enable-tick generator with programmable period and
// glitch-free run-time divisor changes applied only on period boundaries.
// Optional feature macro TICK_SQW_OUT_EN adds a square-wave output sq_out.
module tick_sched_ctrl #(
    parameter int DIV_W       = 16,
    parameter int DIV_DEFAULT = 8,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             running,
    output logic             tick,
    output logic [CNT_W-1:0] tick_count
`ifdef TICK_SQW_OUT_EN
    , output logic           sq_out
`endif
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_STOP = 2'd2;
    localparam logic [DIV_W-1:0] ONE = 1;
    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DIV_DEFAULT);

    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] shd_q, shd_d;
    logic             shv_q, shv_d;
    logic             tick_q, run_q;
    logic [CNT_W-1:0] tcnt_q;
    logic [DIV_W-1:0] n_eff;
    logic             act, wrap, xfer;

    // Effective period and end-of-period decode; a divisor of 0 behaves as 1.
    always_comb begin
        n_eff = (div_q == '0) ? ONE : div_q;
        act   = state_q != S_IDLE;
        wrap  = act && (cnt_q == n_eff - ONE);
        xfer  = cfg_valid && !shv_q;
    end

    // Sequencing: start wins in IDLE; stop wins in RUN and retires at the period end.
    always_comb begin
        state_d = state_q;
        if (state_q == S_IDLE)
            state_d = start ? S_RUN : S_IDLE;
        else if (wrap)
            state_d = (state_q == S_STOP || stop) ? S_IDLE : S_RUN;
        else if (stop)
            state_d = S_STOP;
    end

    // Counter and divisor next-state: IDLE writes go straight to the active divisor,
    // active-state writes park in the shadow until the next wrap.
    always_comb begin
        cnt_d = (!act || wrap) ? '0 : cnt_q + ONE;
        div_d = (!act && xfer) ? cfg_div : (wrap && shv_q) ? shd_q : div_q;
        shd_d = (act && xfer) ? cfg_div : shd_q;
        shv_d = (act && xfer) ? 1'b1 : wrap ? 1'b0 : shv_q;
    end

    // Control and output registers; the tick and running flags are registered views
    // of the wrap decode and active state, so they are glitch-free and aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            div_q   <= DIV_RST;
            shd_q   <= '0;
            shv_q   <= 1'b0;
            tick_q  <= 1'b0;
            run_q   <= 1'b0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            shd_q   <= shd_d;
            shv_q   <= shv_d;
            tick_q  <= wrap;
            run_q   <= act;
            tcnt_q  <= tcnt_q + {{(CNT_W-1){1'b0}}, wrap};
        end
    end

    assign cfg_ready  = !shv_q;
    assign running    = run_q;
    assign tick       = tick_q;
    assign tick_count = tcnt_q;

`ifdef TICK_SQW_OUT_EN
    logic sq_q;

    // Square wave toggles with every tick and simply holds its level while idle.
    always_ff @(posedge clk) begin
        if (reset)
            sq_q <= 1'b0;
        else
            sq_q <= sq_q ^ wrap;
    end

    assign sq_out = sq_q;
`endif
endmodule
